// File: rtl/amp_i2c_slave.sv
// I2C target for the amp frontend config bus: START/STOP decode, 7-bit address
// match, auto-incrementing register pointer, write strobes and read-back.
`timescale 1ns/1ps
module amp_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h2C,
  parameter int         ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              i2c_scl,
  input  logic              i2c_sda_i,
  output logic              i2c_sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_BYTE  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_BYTE  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic sclMeta_q, sclSync_q, sclHist_q;
  logic sdaMeta_q, sdaSync_q, sdaHist_q;

  logic [2:0]        state_q, state_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              sdaOe_q, sdaOe_d;
  logic              busy_q, busy_d;
  logic              rw_q, rw_d;
  logic              firstByte_q, firstByte_d;
  logic              masterAck_q, masterAck_d;
  logic [ADDR_W-1:0] regAddr_q, regAddr_d;
  logic [7:0]        regWdata_q, regWdata_d;
  logic              regWr_q, regWr_d;

  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] byteNext;

  // Idle bus level is high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclHist_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaHist_q <= 1'b1;
    end else begin
      sclMeta_q <= i2c_scl;
      sclSync_q <= sclMeta_q;
      sclHist_q <= sclSync_q;
      sdaMeta_q <= i2c_sda_i;
      sdaSync_q <= sdaMeta_q;
      sdaHist_q <= sdaSync_q;
    end
  end

  assign sclRise  =  sclSync_q & ~sclHist_q;
  assign sclFall  = ~sclSync_q &  sclHist_q;
  assign startDet =  sclSync_q &  sclHist_q & ~sdaSync_q &  sdaHist_q;
  assign stopDet  =  sclSync_q &  sclHist_q &  sdaSync_q & ~sdaHist_q;
  assign byteNext = {shift_q[6:0], sdaSync_q};

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    sdaOe_d     = sdaOe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    firstByte_d = firstByte_q;
    masterAck_d = masterAck_q;
    regAddr_d   = regAddr_q;
    regWdata_d  = regWdata_q;
    regWr_d     = 1'b0;

    // The pointer advances on the clock after each write strobe.
    if (regWr_q) regAddr_d = regAddr_q + ADDR_W'(1);

    if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (stopDet) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (sclRise && bitCnt_q < 4'd8) begin
            shift_d  = byteNext;
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              sdaOe_d = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (sclFall) begin
            if (rw_q) begin
              shift_d  = reg_rdata;
              sdaOe_d  = ~reg_rdata[7];
              bitCnt_d = 4'd1;
              state_d  = RD_BYTE;
            end else begin
              sdaOe_d     = 1'b0;
              bitCnt_d    = 4'd0;
              firstByte_d = 1'b1;
              state_d     = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (sclRise && bitCnt_q < 4'd8) begin
            shift_d  = byteNext;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              if (firstByte_q) begin
                regAddr_d   = byteNext[ADDR_W-1:0];
                firstByte_d = 1'b0;
              end else begin
                regWdata_d = byteNext;
                regWr_d    = 1'b1;
              end
            end
          end else if (sclFall && bitCnt_q == 4'd8) begin
            sdaOe_d = 1'b1;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (sclFall) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = 4'd0;
            state_d  = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              sdaOe_d     = 1'b0;
              regAddr_d   = regAddr_q + ADDR_W'(1);
              masterAck_d = 1'b0;
              state_d     = RD_ACK;
            end else begin
              sdaOe_d  = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (sclRise) begin
            masterAck_d = ~sdaSync_q;
          end else if (sclFall) begin
            if (masterAck_q) begin
              shift_d  = reg_rdata;
              sdaOe_d  = ~reg_rdata[7];
              bitCnt_d = 4'd1;
              state_d  = RD_BYTE;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      bitCnt_q    <= 4'd0;
      shift_q     <= 8'd0;
      sdaOe_q     <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      firstByte_q <= 1'b0;
      masterAck_q <= 1'b0;
      regAddr_q   <= '0;
      regWdata_q  <= 8'd0;
      regWr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      sdaOe_q     <= sdaOe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      firstByte_q <= firstByte_d;
      masterAck_q <= masterAck_d;
      regAddr_q   <= regAddr_d;
      regWdata_q  <= regWdata_d;
      regWr_q     <= regWr_d;
    end
  end

  assign i2c_sda_oe = sdaOe_q;
  assign reg_addr   = regAddr_q;
  assign reg_wdata  = regWdata_q;
  assign reg_wr     = regWr_q;
  assign busy       = busy_q;

endmodule
